// File: rtl/axil_init_sequencer_if.sv
// AXI4-Lite bus bundle between the init sequencer (master) and the
// system_controller register slave.
`default_nettype none

interface axil_init_sequencer_if;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

`default_nettype wire

// File: rtl/axil_init_sequencer.sv
// AXI4-Lite master that writes NUM_REGS configuration words, reads each back
// and verifies response and data; reports done or the failing index and cause.
`default_nettype none

module axil_init_sequencer #(
  parameter int unsigned NUM_REGS  = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic                       start,
  input  logic [32*NUM_REGS-1:0]     init_data,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [3:0]                 err_index,
  output logic [2:0]                 err_code,
  axil_init_sequencer_if.master      m_axi
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_WRESP = 3'd2,
    S_RD    = 3'd3,
    S_RDATA = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  localparam logic [15:0] C_TO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [3:0]  C_LAST_IDX = 4'(NUM_REGS - 1);

  localparam logic [2:0] C_ERR_BRESP   = 3'd1;
  localparam logic [2:0] C_ERR_RRESP   = 3'd2;
  localparam logic [2:0] C_ERR_DATA    = 3'd3;
  localparam logic [2:0] C_ERR_TIMEOUT = 3'd4;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_idx;
  logic [31:0] r_shadow [NUM_REGS];
  logic [31:0] r_addr;
  logic        r_aw_done;
  logic        r_w_done;
  logic [15:0] r_cnt;
  logic [3:0]  r_err_index;
  logic [2:0]  r_err_code;

  logic [31:0] w_exp;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_timeout;
  logic        w_launch;
  logic        w_advance;
  logic [2:0]  w_err_code;

  assign busy      = (r_state == S_WR) || (r_state == S_WRESP) ||
                     (r_state == S_RD) || (r_state == S_RDATA);
  assign done      = (r_state == S_DONE);
  assign error     = (r_state == S_ERR);
  assign err_index = r_err_index;
  assign err_code  = r_err_code;

  // VALIDs are decoded from registered state only, so an asynchronous reset
  // drops them immediately and a timeout drops them on the ERR transition.
  assign m_axi.AWADDR  = r_addr;
  assign m_axi.AWPROT  = 3'b000;
  assign m_axi.AWVALID = (r_state == S_WR) && !r_aw_done;
  assign m_axi.WDATA   = w_exp;
  assign m_axi.WSTRB   = 4'hF;
  assign m_axi.WVALID  = (r_state == S_WR) && !r_w_done;
  assign m_axi.BREADY  = (r_state == S_WRESP);
  assign m_axi.ARADDR  = r_addr;
  assign m_axi.ARPROT  = 3'b000;
  assign m_axi.ARVALID = (r_state == S_RD);
  assign m_axi.RREADY  = (r_state == S_RDATA);

  assign w_aw_hs   = m_axi.AWVALID && m_axi.AWREADY;
  assign w_w_hs    = m_axi.WVALID && m_axi.WREADY;
  assign w_timeout = (r_cnt == C_TO_LAST);
  assign w_launch  = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                              (r_state == S_ERR));

  always_comb begin
    w_exp = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r_idx == 4'(i)) w_exp = r_shadow[i];
    end
  end

  always_comb begin
    w_next     = r_state;
    w_err_code = 3'd0;
    w_advance  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) w_next = S_WR;
      end
      S_WR: begin
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
          w_next = S_WRESP;
        end else if (w_timeout) begin
          w_next     = S_ERR;
          w_err_code = C_ERR_TIMEOUT;
        end
      end
      S_WRESP: begin
        if (m_axi.BVALID) begin
          if (m_axi.BRESP == 2'b00) begin
            w_next = S_RD;
          end else begin
            w_next     = S_ERR;
            w_err_code = C_ERR_BRESP;
          end
        end else if (w_timeout) begin
          w_next     = S_ERR;
          w_err_code = C_ERR_TIMEOUT;
        end
      end
      S_RD: begin
        if (m_axi.ARREADY) begin
          w_next = S_RDATA;
        end else if (w_timeout) begin
          w_next     = S_ERR;
          w_err_code = C_ERR_TIMEOUT;
        end
      end
      S_RDATA: begin
        if (m_axi.RVALID) begin
          if (m_axi.RRESP != 2'b00) begin
            w_next     = S_ERR;
            w_err_code = C_ERR_RRESP;
          end else if (m_axi.RDATA != w_exp) begin
            w_next     = S_ERR;
            w_err_code = C_ERR_DATA;
          end else if (r_idx == C_LAST_IDX) begin
            w_next = S_DONE;
          end else begin
            w_next    = S_WR;
            w_advance = 1'b1;
          end
        end else if (w_timeout) begin
          w_next     = S_ERR;
          w_err_code = C_ERR_TIMEOUT;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_addr      <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_cnt       <= '0;
      r_err_index <= '0;
      r_err_code  <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_shadow[i] <= '0;
    end else begin
      r_state <= w_next;

      if (w_next != r_state) r_cnt <= '0;
      else if (busy)         r_cnt <= r_cnt + 16'd1;

      // AW and W complete independently; remember which one is already done.
      if (r_state != S_WR) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end

      if (w_launch) begin
        for (int i = 0; i < NUM_REGS; i++) r_shadow[i] <= init_data[32*i +: 32];
        r_idx       <= '0;
        r_addr      <= BASE_ADDR;
        r_err_index <= '0;
        r_err_code  <= '0;
      end else if (w_advance) begin
        r_idx  <= r_idx + 4'd1;
        r_addr <= r_addr + 32'd4;
      end else if ((w_next == S_ERR) && (r_state != S_ERR)) begin
        r_err_index <= r_idx;
        r_err_code  <= w_err_code;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axil_init_sequencer.sv
// Directed bench for axil_init_sequencer with a configurable AXI4-Lite slave
// (AWREADY delay, BRESP error, readback corruption, stuck ARREADY).
`default_nettype none

module tb_axil_init_sequencer;

  logic         ACLK;
  logic         ARESETN;
  logic         start;
  logic [127:0] init_data;
  logic         busy;
  logic         done;
  logic         error;
  logic [3:0]   err_index;
  logic [2:0]   err_code;

  axil_init_sequencer_if m_axi ();

  axil_init_sequencer #(
    .NUM_REGS  (4),
    .BASE_ADDR (32'h0000_0000),
    .TIMEOUT   (255)
  ) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .start     (start),
    .init_data (init_data),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_index (err_index),
    .err_code  (err_code),
    .m_axi     (m_axi)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_tests = 0;
  int n_fail  = 0;

  // slave configuration
  int cfg_aw_delay    = 0;
  bit cfg_ar_ready    = 1'b1;
  int cfg_bresp_idx   = -1;
  int cfg_corrupt_idx = -1;

  logic [31:0] mem [16];
  logic        aw_have, w_have;
  logic [31:0] s_addr, s_data;
  int          aw_wait;
  logic        aw_hs, w_hs;
  logic [31:0] cur_a, cur_d;

  assign m_axi.AWREADY = m_axi.AWVALID && (aw_wait >= cfg_aw_delay);
  assign m_axi.WREADY  = 1'b1;
  assign m_axi.ARREADY = cfg_ar_ready;
  assign aw_hs = m_axi.AWVALID && m_axi.AWREADY;
  assign w_hs  = m_axi.WVALID && m_axi.WREADY;
  assign cur_a = aw_hs ? m_axi.AWADDR : s_addr;
  assign cur_d = w_hs ? m_axi.WDATA : s_data;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_have      <= 1'b0;
      w_have       <= 1'b0;
      s_addr       <= '0;
      s_data       <= '0;
      aw_wait      <= 0;
      m_axi.BVALID <= 1'b0;
      m_axi.BRESP  <= 2'b00;
      m_axi.RVALID <= 1'b0;
      m_axi.RDATA  <= '0;
      m_axi.RRESP  <= 2'b00;
    end else begin
      if (aw_hs) aw_wait <= 0;
      else if (m_axi.AWVALID) aw_wait <= aw_wait + 1;
      if (aw_hs) begin aw_have <= 1'b1; s_addr <= m_axi.AWADDR; end
      if (w_hs)  begin w_have  <= 1'b1; s_data <= m_axi.WDATA;  end
      if (m_axi.BVALID && m_axi.BREADY) m_axi.BVALID <= 1'b0;
      if ((aw_have || aw_hs) && (w_have || w_hs)) begin
        mem[cur_a[5:2]] <= cur_d;
        m_axi.BVALID    <= 1'b1;
        m_axi.BRESP     <= (int'(cur_a[5:2]) == cfg_bresp_idx) ? 2'b10 : 2'b00;
        aw_have         <= 1'b0;
        w_have          <= 1'b0;
      end
      if (m_axi.ARVALID && m_axi.ARREADY) begin
        m_axi.RVALID <= 1'b1;
        m_axi.RRESP  <= 2'b00;
        m_axi.RDATA  <= (int'(m_axi.ARADDR[5:2]) == cfg_corrupt_idx) ?
                        32'habcd_0000 : mem[m_axi.ARADDR[5:2]];
      end else if (m_axi.RVALID && m_axi.RREADY) begin
        m_axi.RVALID <= 1'b0;
      end
    end
  end

  // free-running bus monitor; tests work on deltas of these counters
  int          aw_hi = 0, w_hi = 0, ar_hi = 0, aw_unstable = 0, aw_cnt = 0;
  int          ar_vis [16];
  logic [31:0] aw_log [64];
  logic        aw_pend = 1'b0;
  logic [31:0] aw_prev = '0;

  always @(negedge ACLK) begin
    if (m_axi.AWVALID) aw_hi++;
    if (m_axi.WVALID)  w_hi++;
    if (m_axi.ARVALID) begin
      ar_hi++;
      ar_vis[m_axi.ARADDR[5:2]]++;
    end
    if (aw_hs && aw_cnt < 64) begin
      aw_log[aw_cnt] = m_axi.AWADDR;
      aw_cnt++;
    end
    if (m_axi.AWVALID && aw_pend && (m_axi.AWADDR != aw_prev)) aw_unstable++;
    aw_pend = m_axi.AWVALID && !m_axi.AWREADY;
    aw_prev = m_axi.AWADDR;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller sits just after a rising edge. cyc counts edges after the one that
  // samples start; extra_at re-pulses start in that cycle.
  task automatic run_seq(input int limit, input int extra_at, output int cyc);
    start = 1'b1;
    @(posedge ACLK); #1;
    start = 1'b0;
    cyc   = 1;
    while (!(done || error) && cyc < limit) begin
      start = (cyc == extra_at);
      @(posedge ACLK); #1;
      cyc++;
    end
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp_w [4];
  int          cyc, b_aw, b_w, b_ar, b_unst, b_cnt, b_ar2;

  initial begin
    for (int i = 0; i < 16; i++) begin
      ar_vis[i] = 0;
      mem[i]    = '0;
    end
    exp_w[0] = 32'h0101_FFFF;
    exp_w[1] = 32'habcd_0001;
    exp_w[2] = 32'hdead_0011;
    exp_w[3] = 32'hbeef_0011;
    init_data = {32'hbeef_0011, 32'hdead_0011, 32'habcd_0001, 32'h0101_FFFF};
    ARESETN = 1'b0;
    start   = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;

    check("rst_busy",    32'(busy), 0);
    check("rst_done",    32'(done), 0);
    check("rst_error",   32'(error), 0);
    check("rst_erridx",  32'(err_index), 0);
    check("rst_errcode", 32'(err_code), 0);
    check("rst_valids",  32'({m_axi.AWVALID, m_axi.WVALID, m_axi.ARVALID,
                              m_axi.BREADY, m_axi.RREADY}), 0);
    check("rst_awaddr",  m_axi.AWADDR, 0);
    check("rst_wdata",   m_axi.WDATA, 0);
    check("rst_araddr",  m_axi.ARADDR, 0);

    ARESETN = 1'b1;
    @(posedge ACLK); #1;

    // zero-wait slave: 4 registers, done 17 cycles after start
    b_cnt = aw_cnt; b_ar = ar_hi;
    run_seq(100, -1, cyc);
    check("t1_cycles", 32'(cyc), 17);
    check("t1_done",   32'(done), 1);
    check("t1_error",  32'(error), 0);
    check("t1_busy",   32'(busy), 0);
    check("t1_nwrites", 32'(aw_cnt - b_cnt), 4);
    check("t1_nreads",  32'(ar_hi - b_ar), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_awaddr%0d", i), aw_log[b_cnt + i], 32'(4 * i));
      check($sformatf("t1_mem%0d", i), mem[i], exp_w[i]);
    end

    // AWREADY low for 2 cycles of each AWVALID, WREADY immediate
    cfg_aw_delay = 2;
    b_aw = aw_hi; b_w = w_hi; b_unst = aw_unstable;
    run_seq(100, -1, cyc);
    check("t2_cycles",   32'(cyc), 25);
    check("t2_done",     32'(done), 1);
    check("t2_aw_hi",    32'(aw_hi - b_aw), 12);
    check("t2_w_hi",     32'(w_hi - b_w), 4);
    check("t2_aw_stable", 32'(aw_unstable - b_unst), 0);
    cfg_aw_delay = 0;

    // BRESP SLVERR on register 2
    cfg_bresp_idx = 2;
    b_ar2 = ar_vis[2];
    run_seq(100, -1, cyc);
    check("t3_cycles",  32'(cyc), 11);
    check("t3_error",   32'(error), 1);
    check("t3_done",    32'(done), 0);
    check("t3_erridx",  32'(err_index), 2);
    check("t3_errcode", 32'(err_code), 1);
    check("t3_no_ar2",  32'(ar_vis[2] - b_ar2), 0);
    cfg_bresp_idx = -1;

    // register 1 readback corrupted
    cfg_corrupt_idx = 1;
    run_seq(100, -1, cyc);
    check("t4_cycles",  32'(cyc), 9);
    check("t4_error",   32'(error), 1);
    check("t4_done",    32'(done), 0);
    check("t4_erridx",  32'(err_index), 1);
    check("t4_errcode", 32'(err_code), 3);
    cfg_corrupt_idx = -1;

    // ARREADY stuck low: ARVALID held TIMEOUT cycles, then timeout error
    cfg_ar_ready = 1'b0;
    b_ar = ar_hi;
    run_seq(400, -1, cyc);
    check("t5_cycles",  32'(cyc), 258);
    check("t5_ar_hi",   32'(ar_hi - b_ar), 255);
    check("t5_error",   32'(error), 1);
    check("t5_errcode", 32'(err_code), 4);
    check("t5_erridx",  32'(err_index), 0);
    check("t5_arvalid", 32'(m_axi.ARVALID), 0);
    cfg_ar_ready = 1'b1;
    run_seq(100, -1, cyc);
    check("t5_retry_done",    32'(done), 1);
    check("t5_retry_errcode", 32'(err_code), 0);
    check("t5_retry_cycles",  32'(cyc), 17);

    // asynchronous reset while in WRESP of register 1
    start = 1'b1;
    @(posedge ACLK); #1;
    start = 1'b0;
    repeat (5) @(posedge ACLK);
    #1;
    check("t6_pre_bready", 32'(m_axi.BREADY), 1);
    check("t6_pre_awaddr", m_axi.AWADDR, 32'h4);
    #2 ARESETN = 1'b0;
    #1;
    check("t6_rst_bready", 32'(m_axi.BREADY), 0);
    check("t6_rst_busy",   32'(busy), 0);
    check("t6_rst_awaddr", m_axi.AWADDR, 0);
    check("t6_rst_wdata",  m_axi.WDATA, 0);
    check("t6_rst_valids", 32'({m_axi.AWVALID, m_axi.WVALID, m_axi.ARVALID,
                                m_axi.RREADY, done, error}), 0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    b_cnt = aw_cnt;
    run_seq(100, 3, cyc);
    check("t6_cycles",   32'(cyc), 17);
    check("t6_done",     32'(done), 1);
    check("t6_first_aw", aw_log[b_cnt], 32'h0);
    check("t6_nwrites",  32'(aw_cnt - b_cnt), 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
